// File: rtl/lcg128_source.sv
// Purpose: 128-bit LCG word source (S = S*MULT + INC) with an iterative 4-step multiply.
// Latency: enable sampled in IDLE -> out_valid six cycles later; one word per 6 cycles back-to-back.
// Backpressure: word held in HOLD until out_ready; no new step starts until it is consumed.
module lcg128_source #(
    parameter logic [127:0] MULT       = 128'h2360ED051FC65DA44385DF649FCCF645,
    parameter logic [127:0] INC        = 128'h5851F42D4C957F2D14057B7EF767814F,
    parameter logic [127:0] RESET_SEED = 128'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         seed_load,
    input  logic [127:0] seed,
    output logic [127:0] data_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic [31:0]  gen_count
);

    typedef enum logic [1:0] {IDLE, MUL, ADD, HOLD} state_t;

    state_t         state_q, state_d;
    logic [1:0]     k_q, k_d;
    logic [127:0]   acc_q, acc_d;
    logic [127:0]   s_q, s_d;
    logic [127:0]   data_q, data_d;
    logic           valid_q, valid_d;
    logic [31:0]    cnt_q, cnt_d;

    logic [31:0]    mult_chunk;
    logic [127:0]   partial;

    // Partial product of the state with the 32-bit multiplier slice selected by k.
    always_comb begin
        mult_chunk = MULT[31:0];
        case (k_q)
            2'd0:    mult_chunk = MULT[31:0];
            2'd1:    mult_chunk = MULT[63:32];
            2'd2:    mult_chunk = MULT[95:64];
            default: mult_chunk = MULT[127:96];
        endcase
        partial = (s_q * {96'd0, mult_chunk}) << {k_q, 5'd0};
    end

    // Next-state and datapath; a seed load overrides whatever step is in flight.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        s_d     = s_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = MUL;
                    k_d     = 2'd0;
                    acc_d   = '0;
                end
            end
            MUL: begin
                acc_d = acc_q + partial;
                k_d   = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                s_d     = acc_q + INC;
                data_d  = acc_q + INC;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + 32'd1;
                    if (enable) begin
                        state_d = MUL;
                        k_d     = 2'd0;
                        acc_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (seed_load) begin
            s_d     = seed;
            valid_d = 1'b0;
            state_d = IDLE;
            k_d     = 2'd0;
            acc_d   = acc_q;
            data_d  = data_q;
            cnt_d   = cnt_q;
        end
    end

    // State registers with synchronous reset taking priority over all requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            acc_q   <= '0;
            s_q     <= RESET_SEED;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign gen_count = cnt_q;
    assign busy      = (state_q == MUL) || (state_q == ADD);

endmodule

// File: tb/tb_lcg128_source.sv
module tb_lcg128_source;

    localparam logic [127:0] A = 128'h2360ED051FC65DA44385DF649FCCF645;
    localparam logic [127:0] C = 128'h5851F42D4C957F2D14057B7EF767814F;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic         seed_load = 1'b0;
    logic [127:0] seed = '0;
    logic [127:0] data_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;
    logic [31:0]  gen_count;

    int vectors = 0;
    int miscompares = 0;

    lcg128_source dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .seed_load (seed_load),
        .seed      (seed),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .gen_count (gen_count)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] lcg(input logic [127:0] s);
        return s * A + C;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step_clk;
        @(posedge clk);
        #1;
    endtask

    // Runs clocks until out_valid, returns edges taken including the current one.
    task automatic wait_valid(output int n);
        n = 1;
        step_clk();
        enable = 1'b0;
        while (!out_valid && n < 20) begin
            step_clk();
            n++;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step_clk();
        step_clk();
        rst = 1'b0;
    endtask

    task automatic do_seed(input logic [127:0] v);
        seed_load = 1'b1;
        seed = v;
        step_clk();
        seed_load = 1'b0;
    endtask

    // Reference model: the last seeded or consumed state and the handshake count.
    logic [127:0] m_s = '0;
    int unsigned  m_cnt = 0;
    bit           armed = 1'b0;

    always @(negedge clk) begin
        if (armed) begin
            chk("gen_count_model", {96'd0, gen_count}, {96'd0, m_cnt});
            if (out_valid) begin
                chk("data_model", data_out, lcg(m_s));
            end
            chk("valid_while_busy", {127'd0, out_valid & busy}, 128'd0);
        end
        if (rst) begin
            m_s   = '0;
            m_cnt = 0;
            armed = 1'b1;
        end else if (armed) begin
            if (seed_load) begin
                m_s = seed;
            end else if (out_valid && out_ready) begin
                m_s = lcg(m_s);
                m_cnt++;
            end
        end
    end

    initial begin
        int n;
        int cyc;
        int last;
        int nval;
        logic [127:0] held;

        // Reset state
        do_reset();
        chk("rst_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_data", data_out, 128'd0);
        chk("rst_count", {96'd0, gen_count}, 128'd0);

        // Seed 0, one step, consumed immediately
        do_seed(128'd0);
        out_ready = 1'b1;
        enable = 1'b1;
        wait_valid(n);
        chk("latency_seed0", 128'(n), 128'd6);
        chk("word_seed0", data_out, 128'h5851F42D4C957F2D14057B7EF767814F);
        step_clk();
        chk("count_after_1", {96'd0, gen_count}, 128'd1);
        chk("valid_after_hs", {127'd0, out_valid}, 128'd0);

        // Seed 1 loaded together with enable: load only, step starts a cycle later
        seed_load = 1'b1;
        seed = 128'd1;
        enable = 1'b1;
        step_clk();
        seed_load = 1'b0;
        chk("seed_en_no_start", {127'd0, busy}, 128'd0);
        wait_valid(n);
        chk("latency_seed1", 128'(n), 128'd6);
        chk("word_seed1", data_out, 128'h7BB2E1326C5BDCD1578B5AE397347794);
        step_clk();

        // Backpressure: hold for 10 cycles, then consume with a follow-on step
        out_ready = 1'b0;
        do_seed(128'd0);
        enable = 1'b1;
        wait_valid(n);
        held = data_out;
        for (int i = 0; i < 10; i++) begin
            step_clk();
        end
        chk("hold_data", data_out, held);
        chk("hold_valid", {127'd0, out_valid}, 128'd1);
        chk("hold_count", {96'd0, gen_count}, 128'd2);
        out_ready = 1'b1;
        enable = 1'b1;
        step_clk();
        out_ready = 1'b0;
        chk("hs_count", {96'd0, gen_count}, 128'd3);
        n = 1;
        enable = 1'b0;
        while (!out_valid && n < 20) begin
            step_clk();
            n++;
        end
        chk("hs_to_next", 128'(n), 128'd6);
        out_ready = 1'b1;
        step_clk();
        out_ready = 1'b0;

        // Seed load at MUL k=2 discards the step
        do_seed(128'd0);
        enable = 1'b1;
        step_clk();
        enable = 1'b0;
        step_clk();
        step_clk();
        seed_load = 1'b1;
        seed = 128'd1;
        step_clk();
        seed_load = 1'b0;
        chk("abort_busy", {127'd0, busy}, 128'd0);
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            step_clk();
            if (out_valid) cyc++;
        end
        chk("abort_no_valid", 128'(cyc), 128'd0);
        enable = 1'b1;
        wait_valid(n);
        chk("abort_then_step", data_out, 128'h7BB2E1326C5BDCD1578B5AE397347794);
        out_ready = 1'b1;
        step_clk();

        // 1000 back-to-back steps
        do_reset();
        out_ready = 1'b1;
        enable = 1'b1;
        nval = 0;
        cyc = 0;
        last = 0;
        while (nval < 1000 && cyc < 8000) begin
            step_clk();
            cyc++;
            if (out_valid) begin
                nval++;
                if (nval == 1) chk("b2b_first", 128'(cyc), 128'd6);
                else chk("b2b_spacing", 128'(cyc - last), 128'd6);
                last = cyc;
                if (nval == 1000) enable = 1'b0;
            end
        end
        chk("b2b_words", 128'(nval), 128'd1000);
        step_clk();
        chk("b2b_count", {96'd0, gen_count}, 128'd1000);

        // Reset mid-MUL discards the word
        enable = 1'b1;
        step_clk();
        enable = 1'b0;
        step_clk();
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        chk("rst_mul_busy", {127'd0, busy}, 128'd0);
        chk("rst_mul_count", {96'd0, gen_count}, 128'd0);

        // Reset in HOLD, with out_ready high on the same edge
        do_seed(128'd5);
        out_ready = 1'b0;
        enable = 1'b1;
        wait_valid(n);
        out_ready = 1'b1;
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        out_ready = 1'b0;
        chk("rst_hold_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_hold_data", data_out, 128'd0);
        chk("rst_hold_count", {96'd0, gen_count}, 128'd0);
        chk("rst_hold_busy", {127'd0, busy}, 128'd0);
        step_clk();
        step_clk();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcg128_source.md
LCG128_SOURCE -- requirements
Module: lcg128_source

Interface
REQ-001 Parameter MULT, default 128'h2360ED051FC65DA44385DF649FCCF645, LCG multiplier A.
REQ-002 Parameter INC, default 128'h5851F42D4C957F2D14057B7EF767814F, LCG increment C; SHALL be odd.
REQ-003 Parameter RESET_SEED, default 128'h0, state value loaded by reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  permits a new LCG step to start.
REQ-007 seed_load  input  1  one-cycle request to load seed into the state.
REQ-008 seed  input  128  seed value, sampled when seed_load=1.
REQ-009 data_out  output  128  newest LCG state, the 128-bit word consumed by the permutation stage.
REQ-010 out_valid  output  1  data_out holds an unconsumed value.
REQ-011 out_ready  input  1  downstream accepts data_out.
REQ-012 busy  output  1  high in MUL and ADD states.
REQ-013 gen_count  output  32  number of completed handshakes (out_valid & out_ready).

Function
REQ-014 Recurrence SHALL be S_next = (S*MULT + INC) mod 2^128, unsigned.
REQ-015 FSM states SHALL be IDLE, MUL, ADD, HOLD.
REQ-016 Multiply SHALL be iterative: 4 MUL cycles, k=0..3; each cycle acc <= (acc + ((S * MULT[32k+31:32k]) << 32k)) mod 2^128; acc cleared on MUL entry.
REQ-017 IDLE: enable=1 -> MUL (k=0) next cycle; else stay.
REQ-018 MUL: after k=3 -> ADD.
REQ-019 ADD: S <= acc+INC (mod 2^128); data_out <= same value; out_valid <= 1; -> HOLD.
REQ-020 HOLD: out_valid=1; data_out stable while out_ready=0.
REQ-021 HOLD with out_ready=1: out_valid <= 0, gen_count <= gen_count+1; -> MUL if enable=1, else IDLE.
REQ-022 Latency: enable sampled in IDLE at cycle t -> out_valid=1 at cycle t+6; back-to-back throughput one word per 6 cycles with out_ready held high.
REQ-023 seed_load=1 SHALL take priority in every state: S <= seed, out_valid <= 0, in-flight computation discarded, state -> IDLE; data_out and gen_count unchanged.
REQ-024 seed_load and enable together in IDLE: seed load only; step starts no earlier than next cycle.
REQ-025 gen_count SHALL wrap from 32'hFFFFFFFF to 0.
REQ-026 busy SHALL be 1 exactly in MUL and ADD; out_valid SHALL never be 1 while busy=1.
REQ-027 enable deasserted during MUL/ADD SHALL NOT abort the step; it only prevents the next step from starting.

Reset
REQ-028 rst=1 at a clock edge SHALL set S=RESET_SEED, acc=0, state=IDLE, data_out=0, out_valid=0, busy=0, gen_count=0, overriding seed_load and enable.
REQ-029 rst asserted mid-MUL or in HOLD SHALL discard the pending word; no handshake counted for that cycle.

Verification
REQ-030 Reset, seed_load seed=0, enable=1, out_ready=1 -> out_valid at enable+6 cycles, data_out=5851F42D4C957F2D14057B7EF767814F, gen_count=1.
REQ-031 seed_load seed=1, one step -> data_out=7BB2E1326C5BDCD1578B5AE397347794.
REQ-032 Seed=0, out_ready=0 for 10 cycles in HOLD -> data_out stable, out_valid=1, gen_count=0; raise out_ready -> gen_count=1, next word at handshake+6.
REQ-033 seed_load seed=1 at MUL k=2 of a step from seed 0 -> out_valid stays 0, IDLE; following step yields A+C value above.
REQ-034 1000 back-to-back steps compared against 128-bit reference model; gen_count=1000, handshake spacing exactly 6 cycles.
REQ-035 rst pulsed during HOLD -> next cycle out_valid=0, data_out=0, gen_count=0, state IDLE.
